// File: rtl/f1_reaction_timer.sv
// rtl/f1_reaction_timer.sv - F1 start-light reaction timer with jump-start, timeout and sequence checks
module f1_reaction_timer #(
    parameter int CNT_W   = 16,
    parameter int MAX_CNT = 2**CNT_W - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       lights,
    input  logic             tick,
    input  logic             trigger,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             jump_start,
    output logic             timeout,
    output logic             seq_err
);

    localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(MAX_CNT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMING = 3'd1,
        ALL_ON = 3'd2,
        TIMING = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state_q;
    logic [7:0]       lights_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] result_q;
    logic             busy_q;
    logic             valid_q;
    logic             jump_q;
    logic             timeout_q;
    logic             seq_err_q;

    logic seq_start;
    logic step_legal;

    // A new sequence is the first lamp lighting from a dark bar.
    assign seq_start  = (lights == 8'h01) && (lights_q == 8'h00);
    assign step_legal = (lights == {lights_q[6:0], 1'b1}) || (lights == lights_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lights_q  <= 8'h00;
            cnt_q     <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            jump_q    <= 1'b0;
            timeout_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            lights_q <= lights;
            valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (seq_start) state_q <= ARMING;
                end
                ARMING: begin
                    if (trigger) begin
                        state_q  <= DONE;
                        jump_q   <= 1'b1;
                        result_q <= '0;
                        valid_q  <= 1'b1;
                    end else if (!step_legal) begin
                        state_q   <= DONE;
                        seq_err_q <= 1'b1;
                        valid_q   <= 1'b1;
                    end else if (lights == 8'hFF) begin
                        state_q <= ALL_ON;
                    end
                end
                ALL_ON: begin
                    if (trigger) begin
                        state_q  <= DONE;
                        jump_q   <= 1'b1;
                        result_q <= '0;
                        valid_q  <= 1'b1;
                    end else if (lights == 8'h00) begin
                        state_q <= TIMING;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else if (lights != 8'hFF) begin
                        state_q   <= DONE;
                        seq_err_q <= 1'b1;
                        valid_q   <= 1'b1;
                    end
                end
                TIMING: begin
                    // The trigger reports the count as it stood before any tick in the same cycle.
                    if (trigger) begin
                        state_q  <= DONE;
                        result_q <= cnt_q;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                    end else if (tick) begin
                        if (cnt_q == LAST_V) begin
                            state_q   <= DONE;
                            cnt_q     <= MAX_V;
                            result_q  <= MAX_V;
                            timeout_q <= 1'b1;
                            valid_q   <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (seq_start) begin
                        state_q   <= ARMING;
                        jump_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        seq_err_q <= 1'b0;
                        result_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign jump_start   = jump_q;
    assign timeout      = timeout_q;
    assign seq_err      = seq_err_q;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// tb/tb_f1_reaction_timer.sv - randomized bench for f1_reaction_timer against a behavioural model
module tb_f1_reaction_timer;

    localparam int CNT_W = 4;
    localparam int MAXC  = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       lights = 8'h00;
    logic             tick = 1'b0;
    logic             trigger = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic             result_valid;
    logic             jump_start;
    logic             timeout;
    logic             seq_err;

    int total = 0;
    int bad   = 0;

    f1_reaction_timer #(.CNT_W(CNT_W), .MAX_CNT(MAXC)) dut (
        .clk(clk), .rst(rst), .lights(lights), .tick(tick), .trigger(trigger),
        .busy(busy), .result(result), .result_valid(result_valid),
        .jump_start(jump_start), .timeout(timeout), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    // Reference: phase of the race, elapsed ticks since lights-out, and the reported outcome.
    typedef enum int {P_WAIT, P_COUNTDOWN, P_FULL, P_RACE, P_RESULT} phase_t;
    phase_t m_phase = P_WAIT;
    int     m_prev = 0;
    int     m_ticks = 0;
    int     m_res = 0;
    bit     m_rv = 0, m_js = 0, m_to = 0, m_se = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic report(input bit [1:0] why, input int res);
        m_phase = P_RESULT;
        m_rv    = 1;
        m_res   = res;
        if (why == 1) m_js = 1;
        if (why == 2) m_se = 1;
        if (why == 3) m_to = 1;
    endtask

    task automatic model(input int l, input bit tk, input bit tr, input bit r);
        bit fresh, legal;
        m_rv = 0;
        if (r) begin
            m_phase = P_WAIT; m_prev = 0; m_ticks = 0; m_res = 0;
            m_js = 0; m_to = 0; m_se = 0;
            return;
        end
        fresh = (l == 1) && (m_prev == 0);
        legal = (l == m_prev) || (l == (((m_prev * 2) + 1) % 256));
        case (m_phase)
            P_WAIT:      if (fresh) m_phase = P_COUNTDOWN;
            P_COUNTDOWN: begin
                if (tr) report(1, 0);
                else if (!legal) report(2, m_res);
                else if (l == 255) m_phase = P_FULL;
            end
            P_FULL: begin
                if (tr) report(1, 0);
                else if (l == 0) begin m_phase = P_RACE; m_ticks = 0; end
                else if (l != 255) report(2, m_res);
            end
            P_RACE: begin
                if (tr) report(0, m_ticks);
                else if (tk) begin
                    m_ticks = m_ticks + 1;
                    if (m_ticks >= MAXC) report(3, MAXC);
                end
            end
            P_RESULT: if (fresh) begin
                m_phase = P_COUNTDOWN; m_js = 0; m_to = 0; m_se = 0; m_res = 0;
            end
            default: m_phase = P_WAIT;
        endcase
        m_prev = l;
    endtask

    task automatic step(input logic [7:0] l, input bit tk, input bit tr, input bit r);
        lights = l; tick = tk; trigger = tr; rst = r;
        @(posedge clk);
        model(int'(l), tk, tr, r);
        #1;
        check("busy", 32'(busy), 32'(m_phase == P_RACE));
        check("result", 32'(result), 32'(m_res));
        check("result_valid", 32'(result_valid), 32'(m_rv));
        check("jump_start", 32'(jump_start), 32'(m_js));
        check("timeout", 32'(timeout), 32'(m_to));
        check("seq_err", 32'(seq_err), 32'(m_se));
    endtask

    task automatic ramp_to_full();
        for (int i = 1; i <= 8; i++) step(8'((1 << i) - 1), 1'b0, 1'b0, 1'b0);
    endtask

    // kind: 0 clean, 1 early trigger, 2 corrupted lights, 3 reset injection
    task automatic run_seq(input int kind);
        logic [7:0] l;
        bit tr, r;
        int n;
        repeat ($urandom_range(1, 3)) step(8'h00, 1'($urandom), 1'($urandom), 1'b0);
        for (int i = 1; i <= 8; i++) begin
            repeat ($urandom_range(1, 3)) begin
                l = 8'((1 << i) - 1); tr = 0; r = 0;
                if (kind == 1 && $urandom_range(0, 11) == 0) tr = 1;
                if (kind == 2 && $urandom_range(0, 11) == 0) l = 8'($urandom);
                if (kind == 3 && $urandom_range(0, 14) == 0) r = 1;
                step(l, 1'($urandom), tr, r);
            end
        end
        repeat ($urandom_range(0, 3)) step(8'hFF, 1'($urandom), 1'b0, 1'b0);
        step(8'h00, 1'($urandom), 1'b0, 1'b0);
        n = $urandom_range(0, 45);
        for (int j = 0; j < n; j++) begin
            l = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            r = (kind == 3 && $urandom_range(0, 19) == 0);
            step(l, $urandom_range(0, 2) == 0, 1'b0, r);
        end
        step(8'h00, 1'($urandom), 1'b1, 1'b0);
        repeat ($urandom_range(1, 4)) step(8'h00, 1'($urandom), 1'($urandom), 1'b0);
    endtask

    initial begin
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        check("reset_result", 32'(result), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // Clean run with five ticks before the trigger.
        step(8'h00, 1'b0, 1'b0, 1'b0);
        ramp_to_full();
        step(8'h00, 1'b0, 1'b0, 1'b0);
        repeat (5) step(8'h00, 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        check("normal_result", 32'(result), 32'd5);
        check("normal_valid", 32'(result_valid), 32'd1);

        // Trigger together with a tick at count three reports three.
        step(8'h00, 1'b0, 1'b0, 1'b0);
        ramp_to_full();
        step(8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) step(8'h00, 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b1, 1'b1, 1'b0);
        check("tick_trigger_result", 32'(result), 32'd3);

        // No trigger: timeout at the saturation value.
        step(8'h00, 1'b0, 1'b0, 1'b0);
        ramp_to_full();
        step(8'h00, 1'b0, 1'b0, 1'b0);
        repeat (MAXC) step(8'h00, 1'b1, 1'b0, 1'b0);
        check("timeout_flag", 32'(timeout), 32'd1);
        check("timeout_result", 32'(result), 32'(MAXC));
        step(8'h00, 1'b1, 1'b1, 1'b0);
        check("timeout_single_pulse", 32'(result_valid), 32'd0);

        for (int s = 0; s < 300; s++) run_seq($urandom_range(0, 3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
